mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Memory-mapped I/O responder for the CPU memory (MW) stage.
- Decodes load/store requests in the 0x8000_00xx I/O window.
- Bridges the on-chip UART ready/valid ports to CPU loads and stores, with an RX byte FIFO and a TX holding register.
- Also maintains the cycle and retired-instruction counters.
- Read data returns with one-cycle latency, matching dmem/bios_mem.

Parameters:
- RX_FIFO_DEPTH, 8: RX byte FIFO entries; power of two, at least 2.
- IO_BASE, 32'h8000_0000: base address of the I/O window.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_en  input  1  CPU access to I/O window this cycle
- req_we  input  4  byte write enables; any nonzero bit means store, 0 means load
- req_addr  input  32  byte address; addr[1:0] ignored
- req_wdata  input  32  store data
- rdata  output  32  load data, valid the cycle after the load request
- inst_retired  input  1  one instruction retired this cycle
- uart_rx_data_out  input  8  byte from UART receiver
- uart_rx_data_out_valid  input  1  receiver byte valid
- uart_rx_data_out_ready  output  1  ready to accept receiver byte
- uart_tx_data_in  output  8  byte to UART transmitter
- uart_tx_data_in_valid  output  1  transmitter byte valid
- uart_tx_data_in_ready  input  1  transmitter ready

Behaviour:
- Address map (offsets from IO_BASE):
  - 0x00 status, RO: bit0 = tx_ready (TX holding register empty), bit1 = rx_valid (FIFO non-empty), other bits 0.
  - 0x04 rx data, RO: {24'b0, FIFO head}; a load pops the FIFO.
  - 0x08 tx data, WO: a store captures req_wdata[7:0].
  - 0x10 cycle counter, RO.
  - 0x14 instruction counter, RO.
  - 0x18 counter reset, WO: any store clears both counters.
- Loads to unmapped offsets or WO registers return 0. Stores to unmapped offsets or RO registers are ignored.
- Reset (rst high at a clk edge):
  - rdata=0, FIFO empty (pointers 0, count 0), TX holding register empty.
  - uart_tx_data_in_valid=0, uart_tx_data_in=0.
  - Both counters = 0.
  - rst overrides any same-cycle request and aborts a pending TX byte.
- Read timing: rdata is registered. A load in cycle t samples state as of cycle t, before that cycle's updates, and presents it in t+1. rdata holds its value until the next load.
- RX FIFO:
  - uart_rx_data_out_ready = !full (combinational from count).
  - Push when valid && ready.
  - Pop on a load to 0x04 while non-empty. A pop while empty returns 0 and leaves pointers unchanged.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo RX_FIFO_DEPTH.
  - When full, the receiver is back-pressured; no byte is ever lost or overwritten.
- TX holding register:
  - A store to 0x08 while empty loads the byte and sets uart_tx_data_in_valid=1 from the next cycle.
  - valid stays high with stable data until the cycle valid && uart_tx_data_in_ready; the register empties after that edge.
  - A store to 0x08 while full is dropped; software polls status bit0.
  - A store in the same cycle as the handshake is also dropped, because the register is still full in that cycle.
- Counters (32-bit, wrap at 2^32):
  - Cycle counter increments every cycle not in reset.
  - Instruction counter increments when inst_retired=1.
  - A counter-reset store forces both counters to 0 at that edge, overriding the same-cycle increment.
- A single request is either a load or a store, never both. No FSM states beyond FIFO and TX occupancy are required.

Test Plan:
- Reset, then load 0x80000000 -> rdata=0x00000001 next cycle; uart_rx_data_out_ready=1; uart_tx_data_in_valid=0.
- Push bytes 0x41, 0x42 via the rx handshake, then two loads of 0x80000004 -> rdata 0x41 then 0x42; a third load -> 0; status bit1 goes 1 then 0.
- Push 8 bytes (depth 8) -> ready=0, and a 9th valid byte is not accepted. One pop -> ready=1, the 9th byte is accepted, and subsequent pops return bytes in order.
- Store 0x1FF to 0x80000008 with tx_ready held 0 for 5 cycles -> uart_tx_data_in=0xFF with valid held 5 cycles. A second store 0x55 during that window is dropped. Raise ready -> valid falls after one handshake and status bit0=1.
- Run 100 cycles with inst_retired high on 40 of them -> loads of 0x80000010 and 0x80000014 reflect those counts as of the load cycle. A store to 0x80000018 in the same cycle as inst_retired=1 -> both counters 0 on the next cycle.
- Assert rst while a TX byte is pending and the FIFO holds 3 bytes -> valid=0, FIFO empty, status reads 0x00000001.

Source files
------------

// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - CPU MMIO responder: UART RX FIFO, TX holding register, cycle/instruction counters
module mmio_responder #(
    parameter int          RX_FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE       = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    localparam int               PTR_W     = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(RX_FIFO_DEPTH);

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CRST   = 8'h18;

    logic [7:0]       fifo_q [RX_FIFO_DEPTH];
    logic [7:0]       fifo_d [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        in_window;
    logic        is_load;
    logic        is_store;
    logic [7:0]  offset;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        tx_accept;
    logic        tx_done;
    logic        cnt_clear;
    logic [31:0] load_val;

    // Request decode and handshake qualification
    always_comb begin
        in_window  = (req_addr[31:8] == IO_BASE[31:8]);
        offset     = {req_addr[7:2], 2'b00};
        is_load    = req_en && in_window && (req_we == 4'b0000);
        is_store   = req_en && in_window && (req_we != 4'b0000);
        fifo_full  = (count_q == DEPTH_CNT);
        fifo_empty = (count_q == '0);
        push       = uart_rx_data_out_valid && !fifo_full;
        pop        = is_load && (offset == OFF_RX) && !fifo_empty;
        tx_done    = tx_valid_q && uart_tx_data_in_ready;
        // Only an empty holding register can accept; a store during the handshake cycle is dropped
        tx_accept  = is_store && (offset == OFF_TX) && !tx_valid_q;
        cnt_clear  = is_store && (offset == OFF_CRST);
    end

    // Load data mux: reads see the state before this cycle's updates
    always_comb begin
        load_val = 32'h0;
        case (offset)
            OFF_STATUS: load_val = {30'h0, !fifo_empty, !tx_valid_q};
            OFF_RX:     load_val = fifo_empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
            OFF_CYC:    load_val = cyc_q;
            OFF_INST:   load_val = inst_q;
            default:    load_val = 32'h0;
        endcase
    end

    // Next-state computation for FIFO, TX holding register, counters and read data
    always_comb begin
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        rdata_d    = rdata_q;

        if (push) begin
            fifo_d[wr_ptr_q] = uart_rx_data_out;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (tx_done) begin
            tx_valid_d = 1'b0;
        end
        if (tx_accept) begin
            tx_valid_d = 1'b1;
            tx_data_d  = req_wdata[7:0];
        end

        if (is_load) begin
            rdata_d = load_val;
        end

        if (cnt_clear) begin
            cyc_d  = 32'h0;
            inst_d = 32'h0;
        end else begin
            cyc_d  = cyc_q + 32'd1;
            inst_d = inst_q + {31'h0, inst_retired};
        end
    end

    // Control and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h0;
            cyc_q      <= 32'h0;
            inst_q     <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            cyc_q      <= cyc_d;
            inst_q     <= inst_d;
            rdata_q    <= rdata_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count/pointers
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign rdata                  = rdata_q;
    assign uart_rx_data_out_ready = !fifo_full;
    assign uart_tx_data_in        = tx_data_q;
    assign uart_tx_data_in_valid  = tx_valid_q;

endmodule

// File: tb/tb_mmio_responder.sv
// tb/tb_mmio_responder.sv - scoreboard bench for mmio_responder with a queue-based reference model
module tb_mmio_responder;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CYC    = 32'h8000_0010;
    localparam logic [31:0] A_INST   = 32'h8000_0014;
    localparam logic [31:0] A_CRST   = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_en = 1'b0;
    logic [3:0]  req_we = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    mmio_responder #(.RX_FIFO_DEPTH(DEPTH), .IO_BASE(32'h8000_0000)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_en                 (req_en),
        .req_we                 (req_we),
        .req_addr               (req_addr),
        .req_wdata              (req_wdata),
        .rdata                  (rdata),
        .inst_retired           (inst_retired),
        .uart_rx_data_out       (rx_data),
        .uart_rx_data_out_valid (rx_valid),
        .uart_rx_data_out_ready (rx_ready),
        .uart_tx_data_in        (tx_data),
        .uart_tx_data_in_valid  (tx_valid),
        .uart_tx_data_in_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0]  m_fifo[$];
    bit          m_tx_pend;
    logic [7:0]  m_tx_byte;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;
    bit          model_valid = 0;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // one clock of stimulus; the model advances at the edge
    task automatic step(input bit r, input bit en, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input bit ret, input bit rxv, input logic [7:0] rxb,
                        input bit txr);
        logic [7:0]  off;
        bit          ld, st, do_pop, can_push, hs, tx_acc;
        logic [31:0] e;
        rst = r; req_en = en; req_we = we; req_addr = addr; req_wdata = wd;
        inst_retired = ret; rx_valid = rxv; rx_data = rxb; tx_ready = txr;
        if (model_valid) begin
            check("rx_ready", {31'h0, rx_ready}, {31'h0, m_fifo.size() < DEPTH});
            check("tx_valid", {31'h0, tx_valid}, {31'h0, m_tx_pend});
            if (m_tx_pend) check("tx_data", {24'h0, tx_data}, {24'h0, m_tx_byte});
        end
        off = addr[7:0] & 8'hFC;
        ld  = en && (we == 4'h0) && !r;
        st  = en && (we != 4'h0) && !r;
        if (ld) begin
            case (off)
                8'h00:   e = {30'h0, m_fifo.size() != 0, !m_tx_pend};
                8'h04:   e = (m_fifo.size() != 0) ? {24'h0, m_fifo[0]} : 32'h0;
                8'h10:   e = m_cyc;
                8'h14:   e = m_inst;
                default: e = 32'h0;
            endcase
            exp_q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            m_fifo.delete();
            m_tx_pend = 0;
            m_tx_byte = 8'h0;
            m_cyc = 0;
            m_inst = 0;
            model_valid = 1;
        end else begin
            do_pop   = ld && (off == 8'h04) && (m_fifo.size() != 0);
            can_push = rxv && (m_fifo.size() < DEPTH);
            hs       = m_tx_pend && txr;
            tx_acc   = st && (off == 8'h08) && !m_tx_pend;
            if (do_pop) void'(m_fifo.pop_front());
            if (can_push) m_fifo.push_back(rxb);
            if (hs) m_tx_pend = 0;
            if (tx_acc) begin
                m_tx_pend = 1;
                m_tx_byte = wd[7:0];
            end
            if (st && off == 8'h18) begin
                m_cyc = 0;
                m_inst = 0;
            end else begin
                m_cyc = m_cyc + 1;
                m_inst = m_inst + {31'h0, ret};
            end
        end
        #1;
    endtask

    task automatic idle(input bit txr);
        step(0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 8'h0, txr);
    endtask

    task automatic ld(input logic [31:0] a);
        step(0, 1, 4'h0, a, 32'h0, 0, 0, 8'h0, 0);
    endtask

    task automatic rxpush(input logic [7:0] b);
        step(0, 0, 4'h0, 32'h0, 32'h0, 0, 1, b, 0);
    endtask

    // monitor: compares rdata after every edge against the scoreboard
    bit ld_seen = 0;
    bit rst_seen = 0;
    bit mon_on = 0;
    logic [31:0] last_exp = 32'h0;

    always @(posedge clk) begin
        ld_seen  <= req_en && (req_we == 4'h0) && !rst;
        rst_seen <= rst;
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_seen) begin
            mon_on = 1;
            last_exp = 32'h0;
            check("rdata_reset", rdata, 32'h0);
        end else if (mon_on && ld_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                last_exp = e;
                check("rdata_load", rdata, e);
            end
        end else if (mon_on) begin
            check("rdata_hold", rdata, last_exp);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] offs [8];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};

        // reset and status after reset
        step(1, 1, 4'h0, A_STATUS, 32'h0, 0, 0, 8'h0, 0);
        step(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 8'h0, 0);
        ld(A_STATUS);
        check("ready_after_reset", {31'h0, rx_ready}, 32'h1);
        check("txvalid_after_reset", {31'h0, tx_valid}, 32'h0);

        // two-byte RX path, then pop past empty
        rxpush(8'h41);
        rxpush(8'h42);
        ld(A_STATUS);
        ld(A_RX);
        ld(A_RX);
        ld(A_RX);
        ld(A_STATUS);

        // fill FIFO, back-pressure, then refill after one pop
        for (int i = 0; i < 9; i++) rxpush(8'h10 + 8'(i));
        check("ready_when_full", {31'h0, rx_ready}, 32'h0);
        step(0, 1, 4'h0, A_RX, 32'h0, 0, 1, 8'h99, 0);
        check("ready_after_pop", {31'h0, rx_ready}, 32'h1);
        rxpush(8'h99);
        for (int i = 0; i < 9; i++) ld(A_RX);

        // TX holding register: hold while not ready, drop second store
        step(0, 1, 4'hF, A_TX, 32'h1FF, 0, 0, 8'h0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) step(0, 1, 4'h1, A_TX, 32'h55, 0, 0, 8'h0, 0);
            else idle(0);
            check("tx_hold_data", {24'h0, tx_data}, 32'hFF);
        end
        step(0, 1, 4'h1, A_TX, 32'h66, 0, 0, 8'h0, 1);
        ld(A_STATUS);

        // counters: clear, run 100 cycles with 40 retires, read, clear with retire
        step(0, 1, 4'hF, A_CRST, 32'h0, 0, 0, 8'h0, 0);
        for (int i = 0; i < 100; i++) step(0, 0, 4'h0, 32'h0, 32'h0, (i % 5) < 2, 0, 8'h0, 0);
        ld(A_CYC);
        ld(A_INST);
        step(0, 1, 4'hF, A_CRST, 32'h0, 1, 0, 8'h0, 0);
        ld(A_CYC);
        ld(A_INST);

        // reset with TX pending and three RX bytes
        step(0, 1, 4'h1, A_TX, 32'hA5, 0, 0, 8'h0, 0);
        rxpush(8'h01);
        rxpush(8'h02);
        rxpush(8'h03);
        step(1, 0, 4'h0, 32'h0, 32'h0, 0, 0, 8'h0, 0);
        check("txvalid_after_rst", {31'h0, tx_valid}, 32'h0);
        ld(A_STATUS);
        ld(A_RX);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int unsigned op;
            bit r;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            r  = ($urandom_range(0, 299) == 0);
            a  = 32'h8000_0000 | offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if (op < 4) begin
                step(r, 1, 4'h0, a, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                     8'($urandom), $urandom_range(0, 1));
            end else if (op < 6) begin
                if (a[7:2] == 6'h06 && $urandom_range(0, 3) != 0) a = A_TX;
                step(r, 1, 4'($urandom_range(1, 15)), a, $urandom, $urandom_range(0, 1),
                     $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
            end else begin
                step(r, 0, 4'h0, 32'h0, 32'h0, $urandom_range(0, 1), $urandom_range(0, 1),
                     8'($urandom), $urandom_range(0, 1));
            end
        end

        idle(0);
        idle(0);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
